inv_mix_columns: RTL and testbench

//  Multi-cycle AES InvMixColumns engine for the decrypt datapath; inverse of the

---
 rtl/inv_mix_columns.sv | 147 ++++++++++++++
 tb/tb_inv_mix_columns.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns.sv
// Multi-cycle AES InvMixColumns engine: one column per three cycles via iterated xtime.
// Define INV_MIX_FWD_EN to add the i_fwd port selecting forward MixColumns per state.
module inv_mix_columns (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [127:0] i_state,
   output logic         o_valid,
   input  logic         i_ready,
`ifdef INV_MIX_FWD_EN
   input  logic         i_fwd,
`endif
   output logic [127:0] o_state
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] X2   = 3'd1;
   localparam logic [2:0] X4   = 3'd2;
   localparam logic [2:0] X8   = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   logic [2:0]   state;
   logic [1:0]   col;
   logic [127:0] a_reg;
   logic [31:0]  a2;
   logic [31:0]  a4;
   logic [31:0]  cur;
   logic [31:0]  a8;
   logic [31:0]  res;
   logic         fwd;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [31:0] xtime_w(input logic [31:0] w);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 4; i++)
         r[8*i +: 8] = xtime(w[8*i +: 8]);
      return r;
   endfunction

   function automatic logic [31:0] rotl8(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] rotl16(input logic [31:0] w);
      return {w[15:0], w[31:16]};
   endfunction

   function automatic logic [31:0] rotl24(input logic [31:0] w);
      return {w[7:0], w[31:8]};
   endfunction

   // Row r of a rotl-by-8k word holds row r+k, giving the mod-4 row offsets
   function automatic logic [31:0] col_inv(input logic [31:0] a, input logic [31:0] m2,
                                           input logic [31:0] m4, input logic [31:0] m8);
      logic [31:0] m14, m11, m13, m9;
      m14 = m8 ^ m4 ^ m2;
      m11 = m8 ^ m2 ^ a;
      m13 = m8 ^ m4 ^ a;
      m9  = m8 ^ a;
      return m14 ^ rotl8(m11) ^ rotl16(m13) ^ rotl24(m9);
   endfunction

   function automatic logic [31:0] col_fwd(input logic [31:0] a, input logic [31:0] m2);
      return m2 ^ rotl8(m2 ^ a) ^ rotl16(a) ^ rotl24(a);
   endfunction

   always_comb begin
      cur = '0;
      case (col)
         2'd0:    cur = a_reg[127:96];
         2'd1:    cur = a_reg[95:64];
         2'd2:    cur = a_reg[63:32];
         default: cur = a_reg[31:0];
      endcase
   end

   always_comb begin
      a8  = xtime_w(a4);
      res = fwd ? col_fwd(cur, a2) : col_inv(cur, a2, a4, a8);
   end

   assign o_ready = rst && (state == IDLE);
   assign o_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         col     <= '0;
         a_reg   <= '0;
         a2      <= '0;
         a4      <= '0;
         fwd     <= 1'b0;
         o_state <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  a_reg   <= i_state;
`ifdef INV_MIX_FWD_EN
                  fwd     <= i_fwd;
`else
                  fwd     <= 1'b0;
`endif
                  col     <= '0;
                  a2      <= '0;
                  a4      <= '0;
                  o_state <= '0;
                  state   <= X2;
               end
            end
            X2: begin
               a2    <= xtime_w(cur);
               state <= X4;
            end
            X4: begin
               a4    <= xtime_w(a2);
               state <= X8;
            end
            X8: begin
               case (col)
                  2'd0:    o_state[127:96] <= res;
                  2'd1:    o_state[95:64]  <= res;
                  2'd2:    o_state[63:32]  <= res;
                  default: o_state[31:0]   <= res;
               endcase
               if (col == 2'd3) begin
                  state <= DONE;
               end else begin
                  col   <= col + 2'd1;
                  state <= X2;
               end
            end
            DONE: begin
               if (i_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed bench for inv_mix_columns: vector table, latency, backpressure, resets.
// Forward-mode checks are compiled in when INV_MIX_FWD_EN is defined.
module tb_inv_mix_columns;

   logic         clk;
   logic         rst;
   logic         i_valid;
   logic         o_ready;
   logic [127:0] i_state;
   logic         o_valid;
   logic         i_ready;
   logic [127:0] o_state;
   logic         i_fwd;

   int n_chk;
   int n_fail;

   inv_mix_columns dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_state (i_state),
      .o_valid (o_valid),
      .i_ready (i_ready),
`ifdef INV_MIX_FWD_EN
      .i_fwd   (i_fwd),
`endif
      .o_state (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] din;
      logic [127:0] dexp;
   } vec_t;

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = x; bb = y;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic f);
      logic [127:0] o;
      logic [7:0]   b [4];
      logic [7:0]   c [4];
      o = '0;
      c = f ? '{8'h02, 8'h03, 8'h01, 8'h01} : '{8'h0E, 8'h0B, 8'h0D, 8'h09};
      for (int cc = 0; cc < 4; cc++) begin
         for (int r = 0; r < 4; r++) b[r] = s[127 - 32*cc - 8*r -: 8];
         for (int r = 0; r < 4; r++)
            o[127 - 32*cc - 8*r -: 8] = gmul(c[0], b[r]) ^ gmul(c[1], b[(r+1)%4]) ^
                                         gmul(c[2], b[(r+2)%4]) ^ gmul(c[3], b[(r+3)%4]);
      end
      return o;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a posedge with the engine idle; leaves it idle again.
   task automatic run(input logic [127:0] s, input logic f, output logic [127:0] res,
                      output int lat);
      i_state = s;
      i_fwd   = f;
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      res = o_state;
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
   endtask

   vec_t         vt [4];
   logic [127:0] r, held, x;
   int           lat, seen;

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b0; i_valid = 1'b1; i_ready = 1'b0; i_fwd = 1'b0;
      i_state = 128'hdeadbeef_01234567_89abcdef_cafef00d;

      vt[0] = '{128'h8e4da1bc_9fdc589d_d5d5d7d6_01010101, 128'hdb135345_f20a225c_d4d4d4d5_01010101};
      vt[1] = '{128'hffffffff_80000000_00000000_00000001, 128'hffffffff_41ecdaf7_00000000_090d0b0e};
      vt[2] = '{128'h00000000_00000000_00000000_00000000, 128'h00000000_00000000_00000000_00000000};
      vt[3] = '{128'h01000000_00010000_00000100_00000001, 128'h0e090d0b_0b0e090d_0d0b0e09_090d0b0e};

      // reset held with i_valid asserted
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("rst_o_valid", {127'd0, o_valid}, 128'd0);
         check("rst_o_state", o_state, 128'd0);
         check("rst_o_ready", {127'd0, o_ready}, 128'd0);
      end
      i_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_release_o_ready", {127'd0, o_ready}, 128'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) begin
         check("vec_o_ready", {127'd0, o_ready}, 128'd1);
         run(vt[i].din, 1'b0, r, lat);
         check($sformatf("vec%0d_latency", i), 128'(lat), 128'd12);
         check($sformatf("vec%0d_result", i), r, vt[i].dexp);
         check($sformatf("vec%0d_post_valid", i), {127'd0, o_valid}, 128'd0);
      end

      for (int i = 0; i < 6; i++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         run(x, 1'b0, r, lat);
         check($sformatf("rand%0d_result", i), r, model(x, 1'b0));
      end

      // backpressure at DONE with a second i_valid pulse that must be ignored
      i_state = vt[0].din; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      seen = 0;
      while (!o_valid && seen < 40) begin @(posedge clk); #1; seen++; end
      check("bp_latency", 128'(seen), 128'd12);
      held = o_state;
      check("bp_result", held, vt[0].dexp);
      for (int i = 0; i < 5; i++) begin
         i_valid = (i == 2);
         i_state = 128'h11111111_22222222_33333333_44444444;
         @(posedge clk); #1;
         check("bp_o_valid_hold", {127'd0, o_valid}, 128'd1);
         check("bp_o_state_hold", o_state, held);
         check("bp_o_ready_low", {127'd0, o_ready}, 128'd0);
      end
      i_ready = 1'b1; i_valid = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0; i_valid = 1'b0;
      check("bp_released_valid", {127'd0, o_valid}, 128'd0);
      check("bp_released_ready", {127'd0, o_ready}, 128'd1);
      @(posedge clk); #1;
      check("bp_no_accept_ready", {127'd0, o_ready}, 128'd1);
      check("bp_no_accept_state", o_state, held);

      // reset six cycles into an operation
      i_state = vt[1].din; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("midrst_o_state", o_state, 128'd0);
      check("midrst_o_valid", {127'd0, o_valid}, 128'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (o_valid) seen++;
      end
      check("midrst_no_valid", 128'(seen), 128'd0);
      run(128'd0, 1'b0, r, lat);
      check("midrst_next_latency", 128'(lat), 128'd12);
      check("midrst_next_result", r, 128'd0);

`ifdef INV_MIX_FWD_EN
      run(128'hdb135345_db135345_db135345_db135345, 1'b1, r, lat);
      check("fwd_latency", 128'(lat), 128'd12);
      check("fwd_result", r, 128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc);
      run(r, 1'b0, x, lat);
      check("fwd_roundtrip", x, 128'hdb135345_db135345_db135345_db135345);
      for (int i = 0; i < 1000; i++) begin
         held = {$urandom, $urandom, $urandom, $urandom};
         run(held, 1'b1, r, lat);
         run(r, 1'b0, x, lat);
         check("fwd_rand_roundtrip", x, held);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1);
   end

endmodule
